// File: rtl/i2c_bus_monitor_if.sv
// i2c_bus_monitor_if: raw I2C pad levels in, filtered lines and protocol strobes out
interface i2c_bus_monitor_if;
    logic       scl_in;
    logic       sda_in;
    logic       scl_f;
    logic       sda_f;
    logic       start_pulse;
    logic       stop_pulse;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       first_byte;
    logic       ack_valid;
    logic       ack_bit;
    logic       rw;
    logic       busy;
    modport master (
        output scl_in, sda_in,
        input  scl_f, sda_f, start_pulse, stop_pulse, byte_valid, byte_data,
               first_byte, ack_valid, ack_bit, rw, busy
    );
    modport slave (
        input  scl_in, sda_in,
        output scl_f, sda_f, start_pulse, stop_pulse, byte_valid, byte_data,
               first_byte, ack_valid, ack_bit, rw, busy
    );
endinterface

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C deglitcher and START/STOP/byte/ACK strobe generator
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    i2c_bus_monitor_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, ACK = 2'd2;
    logic [1:0] r_sync [SYNC_STAGES];
    logic [3:0] r_cnt [2];
    logic [1:0] r_filt, r_prev, r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_byte;
    logic       r_first, r_start, r_stop, r_bv, r_av, r_fb, r_ack, r_rw;
    logic [1:0] w_sync;
    logic       w_scl, w_sda, w_start, w_stop, w_rise;
    // bit 0 carries SCL, bit 1 carries SDA throughout the front end
    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_scl   = r_filt[0];
    assign w_sda   = r_filt[1];
    assign w_start = w_scl && r_prev[0] && !w_sda && r_prev[1];
    assign w_stop  = w_scl && r_prev[0] && w_sda && !r_prev[1];
    assign w_rise  = w_scl && !r_prev[0];
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 2'b11;
            r_cnt[0] <= 4'd0;
            r_cnt[1] <= 4'd0;
            r_filt   <= 2'b11;
            r_prev   <= 2'b11;
        end else begin
            r_sync[0] <= {bus.sda_in, bus.scl_in};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_filt;
            for (int j = 0; j < 2; j++) begin
                if (w_sync[j] == r_filt[j]) begin
                    r_cnt[j] <= 4'd0;
                end else if (r_cnt[j] == 4'(FILTER_LEN - 1)) begin
                    r_filt[j] <= w_sync[j];
                    r_cnt[j]  <= 4'd0;
                end else begin
                    r_cnt[j] <= r_cnt[j] + 4'd1;
                end
            end
        end
    end
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 7'd0;
            r_byte    <= 8'd0;
            r_first   <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_bv      <= 1'b0;
            r_av      <= 1'b0;
            r_fb      <= 1'b0;
            r_ack     <= 1'b1;
            r_rw      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_bv    <= 1'b0;
            r_av    <= 1'b0;
            if (w_start) begin
                r_start   <= 1'b1;
                r_first   <= 1'b1;
                r_bit_cnt <= 3'd0;
                r_state   <= DATA;
            end else if (w_stop) begin
                r_stop  <= 1'b1;
                r_state <= IDLE;
            end else if (w_rise && r_state == DATA) begin
                r_shift   <= {r_shift[5:0], w_sda};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte  <= {r_shift, w_sda};
                    r_bv    <= 1'b1;
                    r_fb    <= r_first;
                    r_rw    <= r_first ? w_sda : r_rw;
                    r_state <= ACK;
                end
            end else if (w_rise && r_state == ACK) begin
                r_ack     <= w_sda;
                r_av      <= 1'b1;
                r_first   <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_state   <= DATA;
            end
        end
    end
    assign bus.scl_f       = w_scl;
    assign bus.sda_f       = w_sda;
    assign bus.start_pulse = r_start;
    assign bus.stop_pulse  = r_stop;
    assign bus.byte_valid  = r_bv;
    assign bus.byte_data   = r_byte;
    assign bus.first_byte  = r_fb;
    assign bus.ack_valid   = r_av;
    assign bus.ack_bit     = r_ack;
    assign bus.rw          = r_rw;
    assign bus.busy        = r_state != IDLE;
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: bit-banged I2C stimulus with an event scoreboard on the monitor strobes
module tb_i2c_bus_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    i2c_bus_monitor_if bus();
    i2c_bus_monitor #(.SYNC_STAGES(2), .FILTER_LEN(4)) dut (
        .clk_100mhz(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    localparam int K_START = 0, K_BYTE = 1, K_ACK = 2, K_STOP = 3;
    typedef struct {
        int         k;
        logic [7:0] d;
        logic       f;
        logic       r;
    } ev_t;
    ev_t q[$];
    int n_total = 0;
    int n_bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic want(input int k, input logic [7:0] d, input logic f, input logic r);
        ev_t e;
        e.k = k;
        e.d = d;
        e.f = f;
        e.r = r;
        q.push_back(e);
    endtask
    task automatic seen(input int k, input logic [7:0] d, input logic f, input logic r);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", k, 32'hff);
        end else begin
            e = q.pop_front();
            chk("ev_kind", k, e.k);
            chk("ev_data", d, e.d);
            chk("ev_first", f, e.f);
            chk("ev_flag", r, e.r);
        end
    endtask
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic bit_tx(input logic b);
        bus.sda_in = b;
        wait_n(25);
        bus.scl_in = 1'b1;
        wait_n(50);
        bus.scl_in = 1'b0;
        wait_n(25);
    endtask
    task automatic start_tx();
        want(K_START, 8'h00, 1'b0, 1'b1);
        bus.sda_in = 1'b1;
        wait_n(25);
        bus.scl_in = 1'b1;
        wait_n(25);
        bus.sda_in = 1'b0;
        wait_n(25);
        bus.scl_in = 1'b0;
        wait_n(25);
    endtask
    task automatic stop_tx();
        want(K_STOP, 8'h00, 1'b0, 1'b0);
        bus.sda_in = 1'b0;
        wait_n(25);
        bus.scl_in = 1'b1;
        wait_n(25);
        bus.sda_in = 1'b1;
        wait_n(50);
    endtask
    task automatic byte_tx(input logic [7:0] d, input logic f, input logic r, input logic a);
        want(K_BYTE, d, f, r);
        want(K_ACK, 8'h00, 1'b0, a);
        for (int i = 7; i >= 0; i--) bit_tx(d[i]);
        bit_tx(a);
    endtask
    initial begin
        logic lo;
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (bus.start_pulse) seen(K_START, 8'h00, 1'b0, bus.busy);
                if (bus.byte_valid) seen(K_BYTE, bus.byte_data, bus.first_byte, bus.rw);
                if (bus.ack_valid) seen(K_ACK, 8'h00, 1'b0, bus.ack_bit);
                if (bus.stop_pulse) seen(K_STOP, 8'h00, 1'b0, bus.busy);
            end
        join_none
        wait_n(4);
        chk("rst_scl_f", bus.scl_f, 1);
        chk("rst_sda_f", bus.sda_f, 1);
        chk("rst_ack_bit", bus.ack_bit, 1);
        chk("rst_byte_data", bus.byte_data, 0);
        chk("rst_rw", bus.rw, 0);
        chk("rst_first_byte", bus.first_byte, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobes", {bus.start_pulse, bus.stop_pulse, bus.byte_valid, bus.ack_valid}, 0);
        rst_n = 1'b1;
        wait_n(20);
        start_tx();
        byte_tx(8'hA4, 1'b1, 1'b0, 1'b0);
        byte_tx(8'h3C, 1'b0, 1'b0, 1'b1);
        stop_tx();
        chk("busy_after_stop", bus.busy, 0);
        start_tx();
        byte_tx(8'hA5, 1'b1, 1'b1, 1'b0);
        bit_tx(1'b1);
        bit_tx(1'b0);
        bit_tx(1'b1);
        start_tx();
        byte_tx(8'hA5, 1'b1, 1'b1, 1'b0);
        stop_tx();
        chk("rw_held", bus.rw, 1);
        lo = 1'b0;
        bus.sda_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            lo |= ~bus.sda_f;
        end
        bus.sda_in = 1'b1;
        repeat (15) begin
            @(negedge clk);
            lo |= ~bus.sda_f;
        end
        chk("glitch_sda_f_low", lo, 0);
        want(K_START, 8'h00, 1'b0, 1'b1);
        want(K_STOP, 8'h00, 1'b0, 1'b0);
        bus.sda_in = 1'b0;
        wait_n(5);
        bus.sda_in = 1'b1;
        wait_n(30);
        start_tx();
        bit_tx(1'b0);
        bit_tx(1'b1);
        bit_tx(1'b0);
        bit_tx(1'b1);
        chk("busy_mid_byte", bus.busy, 1);
        rst_n = 1'b0;
        wait_n(1);
        chk("busy_after_reset", bus.busy, 0);
        bus.scl_in = 1'b1;
        bus.sda_in = 1'b1;
        wait_n(10);
        rst_n = 1'b1;
        wait_n(20);
        start_tx();
        byte_tx(8'h5A, 1'b1, 1'b0, 1'b0);
        stop_tx();
        chk("final_byte_data", bus.byte_data, 8'h5A);
        wait_n(20);
        chk("events_outstanding", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Passive I2C front end for the host-side bus (`io_scl`/`io_sda`). It synchronises and deglitches both lines, then detects START, repeated START and STOP conditions. It deserialises bytes and ACK bits into single-cycle strobes. It sits directly upstream of the host-to-power-bus bridge logic in `top`, which uses these strobes to decide transfer direction and when to forward or drive SDA.

## Interface
- `SYNC_STAGES`, 2: flip-flop synchroniser depth per line (minimum 2).
- `FILTER_LEN`, 4: consecutive cycles a synchronised level must hold before the filtered line follows it (1..15).
- `clk_100mhz`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `scl_in`  in  1  raw SCL from pad.
- `sda_in`  in  1  raw SDA from pad (resolved bus level).
- `scl_f`  out  1  filtered SCL.
- `sda_f`  out  1  filtered SDA.
- `start_pulse`  out  1  one-cycle strobe on START or repeated START.
- `stop_pulse`  out  1  one-cycle strobe on STOP.
- `byte_valid`  out  1  one-cycle strobe; `byte_data` holds a complete byte.
- `byte_data`  out  8  last received byte, MSB first on the wire; held until the next byte.
- `first_byte`  out  1  qualifies `byte_valid`: the byte is the address byte after a START.
- `ack_valid`  out  1  one-cycle strobe at the ACK bit sample.
- `ack_bit`  out  1  sampled ACK level (0 = ACK); held until the next ACK.
- `rw`  out  1  R/W bit (byte_data[0]) of the latest address byte; held.
- `busy`  out  1  high from START until STOP.

## Operation
- Synchroniser: `SYNC_STAGES` flops per line, reset to 1.
- Filter, per line: a 4-bit counter is cleared whenever the synchronised level equals the filtered level. Otherwise it increments. When the count reaches `FILTER_LEN`, the filtered level takes the synchronised value and the counter clears.
- Edge detection: compare `scl_f`/`sda_f` with their previous-cycle registered copies.
- START: `sda_f` falls while `scl_f` is high in both the current and previous cycle.
- STOP: `sda_f` rises while `scl_f` is high in both the current and previous cycle.
- If SCL and SDA change in the same cycle, it is not a START/STOP and is treated as a data edge.
- FSM states: IDLE, DATA, ACK.
  - IDLE: SCL rises are ignored. START -> DATA with bit_cnt=0 and first flag set.
  - DATA: each `scl_f` rise shifts `sda_f` into the shift register (MSB first) and increments bit_cnt (3-bit, wraps). On the 8th rise: load `byte_data`, pulse `byte_valid` with `first_byte` = first flag, update `rw` if first, then -> ACK.
  - ACK: the next `scl_f` rise samples `ack_bit`, pulses `ack_valid`, clears the first flag, then -> DATA with bit_cnt=0.
- START in any state (repeated START): pulse `start_pulse`, set the first flag, bit_cnt=0, -> DATA. Any partial byte is discarded.
- STOP in any state: pulse `stop_pulse`, -> IDLE. A partial byte is discarded with no `byte_valid`.
- STOP in IDLE still pulses `stop_pulse`.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - `scl_f`=1, `sda_f`=1, `ack_bit`=1.
  - `byte_data`=0, `rw`=0, `first_byte`=0.
  - All strobes 0, `busy`=0, FSM in IDLE.
- Reset asserted mid-transfer: the next edge returns everything to reset values. No strobes fire in the cycle `rst_n` is sampled low.
- Raw input to filtered output latency: `SYNC_STAGES` + `FILTER_LEN` cycles (6 with defaults) for a stable change.
- A pulse shorter than `FILTER_LEN` cycles after synchronisation is fully suppressed.
- Strobe latency: `start_pulse`, `stop_pulse`, `byte_valid`, `ack_valid` assert in the cycle after the filtered edge that causes them, for exactly 1 cycle.
- `byte_data`, `first_byte` and `rw` are valid in the same cycle as `byte_valid`.
- `busy` rises with `start_pulse` and falls with `stop_pulse`.
- Minimum supported SCL half-period: `FILTER_LEN` + 2 cycles.

## Test plan
- Reset: hold `rst_n`=0 for 4 cycles with lines high -> all outputs at reset values. Release -> no strobes.
- Address write: 100 MHz clock, 1 MHz SCL. START, send 0xA4, slave ACK (SDA=0) -> `start_pulse` once, `byte_valid` with `byte_data`=0xA4, `first_byte`=1, `rw`=0, then `ack_valid` with `ack_bit`=0.
- Data + STOP: continue with 0x3C, NACK, STOP -> `byte_valid` with 0x3C and `first_byte`=0, `ack_bit`=1, `stop_pulse` once, `busy`=0.
- Repeated START: after address 0xA5 plus 3 data bits, issue a START -> `start_pulse`, no `byte_valid` for the partial byte. Next byte 0xA5 reports `first_byte`=1, `rw`=1.
- Glitch: 3-cycle low pulse on SDA while SCL high (`FILTER_LEN`=4) -> `sda_f` unchanged, no START. A 5-cycle pulse -> START detected.
- Reset mid-byte: assert `rst_n`=0 after 4 bits -> `busy`=0 next edge. After release, a fresh START + 0x5A -> `byte_data`=0x5A.
